// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit driving the {hi_we, lo_we, hi, lo} HI/LO write bus.
// Define HILO_MDU_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative either way.
module hilo_mdu #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_BIT  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               inst_valid_i,
  input  logic [2:0]         op_i,
  input  logic [31:0]        rs_data_i,
  input  logic [31:0]        rt_data_i,
  output logic [65:0]        hilo_bus_o,
  output logic               stallreq_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StDone} state_e;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        is_div_q, is_div_d;

  logic        is_signed, rs_neg, rt_neg;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_res;
  logic [31:0] res_hi, res_lo;
`ifdef HILO_MDU_FAST_MUL_EN
  logic [63:0] fast_prod, fast_res;
`endif

  // Only the EX bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall_i;

  always_comb begin
    is_signed = (op_i == OpMult) || (op_i == OpDiv);
    rs_neg    = is_signed & rs_data_i[31];
    rt_neg    = is_signed & rt_data_i[31];
    abs_rs    = rs_neg ? (~rs_data_i + 32'd1) : rs_data_i;
    abs_rt    = rt_neg ? (~rt_data_i + 32'd1) : rt_data_i;
`ifdef HILO_MDU_FAST_MUL_EN
    fast_prod = {32'd0, abs_rs} * {32'd0, abs_rt};
    fast_res  = (rs_neg ^ rt_neg) ? (~fast_prod + 64'd1) : fast_prod;
`endif
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_trial = acc_q[63:31] - {1'b0, b_q};
    mul_res   = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
    if (is_div_q) begin
      res_hi = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      res_lo = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    end else begin
      res_hi = mul_res[63:32];
      res_lo = mul_res[31:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    is_div_d   = is_div_q;
    stallreq_o = 1'b0;
    hilo_bus_o = 66'd0;
    unique case (state_q)
      StIdle: begin
        if (inst_valid_i) begin
          case (op_i)
            OpMthi: hilo_bus_o = {2'b10, rs_data_i, 32'd0};
            OpMtlo: hilo_bus_o = {2'b01, 32'd0, rs_data_i};
            OpMult, OpMultu: begin
`ifdef HILO_MDU_FAST_MUL_EN
              hilo_bus_o = {2'b11, fast_res};
`else
              stallreq_o = 1'b1;
              acc_d      = {32'd0, abs_rt};
              b_d        = abs_rs;
              neg_lo_d   = rs_neg ^ rt_neg;
              neg_hi_d   = 1'b0;
              is_div_d   = 1'b0;
              cnt_d      = 5'd0;
              state_d    = StMulRun;
`endif
            end
            OpDiv, OpDivu: begin
              stallreq_o = 1'b1;
              is_div_d   = 1'b1;
              cnt_d      = 5'd0;
              if (rt_data_i == 32'd0) begin
                // Divide by zero: fixed result, no iteration.
                acc_d    = {rs_data_i, 32'hFFFF_FFFF};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                state_d  = StDone;
              end else begin
                acc_d    = {32'd0, abs_rs};
                b_d      = abs_rt;
                neg_lo_d = rs_neg ^ rt_neg;
                neg_hi_d = rs_neg;
                state_d  = StDivRun;
              end
            end
            default: ;
          endcase
        end
      end
      StMulRun: begin
        stallreq_o = 1'b1;
        acc_d      = {mul_sum, acc_q[31:1]};
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDivRun: begin
        stallreq_o = 1'b1;
        acc_d      = div_trial[32] ? {acc_q[62:0], 1'b0} : {div_trial[31:0], acc_q[30:0], 1'b1};
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        hilo_bus_o = {2'b11, res_hi, res_lo};
        if (!stall_i[EX_BIT]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d    = StIdle;
      stallreq_o = 1'b0;
      hilo_bus_o = 66'd0;
    end
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed, table-driven bench for hilo_mdu with hand-computed HI/LO results.
module tb_hilo_mdu;
  localparam int unsigned STALL_W = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               inst_valid;
  logic [2:0]         op;
  logic [31:0]        rs, rt;
  logic [65:0]        hilo_bus;
  logic               stallreq;
  logic               busy;

  int n_pass  = 0;
  int n_total = 0;

  hilo_mdu #(.STALL_W(STALL_W), .EX_BIT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .stall_i     (stall),
    .flush_i     (flush),
    .inst_valid_i(inst_valid),
    .op_i        (op),
    .rs_data_i   (rs),
    .rt_data_i   (rt),
    .hilo_bus_o  (hilo_bus),
    .stallreq_o  (stallreq),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst_valid = 1'b1; op = o; rs = a; rt = b;
    #1;
  endtask

  task automatic idle_inputs();
    inst_valid = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [65:0] exp_bus;
    bit          run_ok;
    int          lat;
    exp_bus = {2'b11, v.hi, v.lo};
    run_ok  = 1'b1;
    issue(v.op, v.rs, v.rt);
`ifdef HILO_MDU_FAST_MUL_EN
    if (v.op == 3'd1 || v.op == 3'd2) begin
      check($sformatf("v%0d fast bus", idx), hilo_bus, exp_bus);
      check($sformatf("v%0d fast stallreq", idx), {65'd0, stallreq}, 66'd0);
      step(); idle_inputs(); #1;
      check($sformatf("v%0d fast after busy", idx), {65'd0, busy}, 66'd0);
      return;
    end
`endif
    check($sformatf("v%0d issue stallreq", idx), {65'd0, stallreq}, 66'd1);
    step(); idle_inputs(); #1;
    lat = v.dz ? 1 : 33;
    for (int c = 1; c < lat; c++) begin
      if (stallreq !== 1'b1 || hilo_bus[65:64] !== 2'b00) run_ok = 1'b0;
      step();
    end
    if (!v.dz) check($sformatf("v%0d run stallreq", idx), {65'd0, run_ok}, 66'd1);
    check($sformatf("v%0d done bus", idx), hilo_bus, exp_bus);
    check($sformatf("v%0d done stallreq", idx), {65'd0, stallreq}, 66'd0);
    step();
    check($sformatf("v%0d idle bus", idx), hilo_bus, 66'd0);
    check($sformatf("v%0d idle busy", idx), {65'd0, busy}, 66'd0);
  endtask

  initial begin
    vecs[0] = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
    vecs[4] = '{3'd4, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
    vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0};
    vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{3'd3, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

    rst_n = 1'b0; stall = '0; flush = 1'b0;
    idle_inputs();
    #12;
    check("reset bus", hilo_bus, 66'd0);
    check("reset stallreq", {65'd0, stallreq}, 66'd0);
    check("reset busy", {65'd0, busy}, 66'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // MTHI / MTLO are combinational and never stall.
    issue(3'd5, 32'h0000_1234, 32'd0);
    check("mthi bus", hilo_bus, {2'b10, 32'h0000_1234, 32'd0});
    check("mthi stallreq", {65'd0, stallreq}, 66'd0);
    issue(3'd6, 32'hCAFE_0001, 32'd0);
    check("mtlo bus", hilo_bus, {2'b01, 32'd0, 32'hCAFE_0001});
    step(); idle_inputs(); #1;
    check("mt busy", {65'd0, busy}, 66'd0);
    check("reserved op bus", hilo_bus, 66'd0);

    // External EX stall holds DONE for three extra cycles.
    issue(3'd4, 32'd100, 32'd7);
    step(); idle_inputs();
    for (int c = 1; c < 33; c++) step();
    stall = 6'b000100; #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall hold %0d", c), hilo_bus, {2'b11, 32'd2, 32'd14});
      step();
    end
    stall = '0; #1;
    check("stall release bus", hilo_bus, {2'b11, 32'd2, 32'd14});
    step();
    check("stall release idle", {65'd0, busy}, 66'd0);

    // Flush at counter 10 of a DIV.
    issue(3'd3, 32'd1000, 32'd3);
    step(); idle_inputs();
    for (int c = 0; c < 10; c++) step();
    check("pre-flush stallreq", {65'd0, stallreq}, 66'd1);
    flush = 1'b1; #1;
    check("flush stallreq", {65'd0, stallreq}, 66'd0);
    check("flush bus", hilo_bus, 66'd0);
    step(); flush = 1'b0; #1;
    check("post-flush busy", {65'd0, busy}, 66'd0);
    check("post-flush bus", hilo_bus, 66'd0);

    // Flush beats issue.
    @(negedge clk); inst_valid = 1'b1; op = 3'd4; rs = 32'd9; rt = 32'd3; flush = 1'b1; #1;
    check("flush issue stallreq", {65'd0, stallreq}, 66'd0);
    step(); idle_inputs(); flush = 1'b0; #1;
    check("flush issue busy", {65'd0, busy}, 66'd0);

    // Asynchronous reset in the middle of an iterative op.
`ifdef HILO_MDU_FAST_MUL_EN
    issue(3'd4, 32'd100, 32'd7);
`else
    issue(3'd2, 32'd123, 32'd456);
`endif
    step(); idle_inputs();
    for (int c = 0; c < 5; c++) step();
    check("pre-reset busy", {65'd0, busy}, 66'd1);
    rst_n = 1'b0; #1;
    check("mid reset bus", hilo_bus, 66'd0);
    check("mid reset stallreq", {65'd0, stallreq}, 66'd0);
    check("mid reset busy", {65'd0, busy}, 66'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (hilo_bus[65:64] !== 2'b00) begin
        check("post reset no write", hilo_bus, 66'd0);
        break;
      end
    end
    check("post reset busy", {65'd0, busy}, 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
